alu_rs: RTL

ALU_RS -- requirements
Module: alu_rs

---
 rtl/alu_rs_pkg.sv | 27 ++
 rtl/alu_rs_prio_sel.sv | 23 ++
 rtl/alu_rs.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: tag width, RV opcodes
// and the packed operand/payload record held in each entry.
package alu_rs_pkg;

  localparam int TAG_W = 3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] imm;
    logic [5:0]  shamt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
    logic        compressed;
  } rs_entry;

endpackage

// File: rtl/alu_rs_prio_sel.sv
// Lowest-index-wins priority encoder used for both issue selection and
// free-slot allocation in the reservation station.
module rs_prio_sel #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands arrive
// over the CDBs, then issues the lowest-index ready entry to the ALU.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = 4,
  parameter int TAG_W   = alu_rs_pkg::TAG_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_pipline,
  input  logic             disp_valid,
  input  logic [TAG_W-1:0] disp_ins_id,
  input  logic             disp_qj_busy,
  input  logic             disp_qk_busy,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic [31:0]      disp_imm,
  input  logic [5:0]       disp_shamt,
  input  logic [6:0]       disp_opcode,
  input  logic [2:0]       disp_funct3,
  input  logic [6:0]       disp_funct7,
  input  logic [31:0]      disp_pc,
  input  logic             disp_compressed,
  output logic             rs_full,
  input  logic             cdb0_valid,
  input  logic [TAG_W-1:0] cdb0_tag,
  input  logic [31:0]      cdb0_val,
  input  logic             cdb1_valid,
  input  logic [TAG_W-1:0] cdb1_tag,
  input  logic [31:0]      cdb1_val,
  output logic             have_ins,
  output logic [TAG_W-1:0] ins_id,
  output logic [31:0]      rs1_val,
  output logic [31:0]      rs2_val,
  output logic [31:0]      imm_val,
  output logic [5:0]       shamt_val,
  output logic [6:0]       opcode,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [31:0]      request_PC,
  output logic             is_compressed_ins
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy, qj_busy, qk_busy;
  logic [RS_SIZE-1:0] ready_vec, hit_j, hit_k;
  logic [TAG_W-1:0]   qj [RS_SIZE];
  logic [TAG_W-1:0]   qk [RS_SIZE];
  logic [TAG_W-1:0]   ent_id [RS_SIZE];
  rs_entry            ent [RS_SIZE];
  logic [31:0]        wake_vj [RS_SIZE];
  logic [31:0]        wake_vk [RS_SIZE];

  logic             sel_found, free_found, do_disp;
  logic [IDX_W-1:0] sel_idx, free_idx;
  logic [32:0]      disp_snj, disp_snk;
  rs_entry          disp_ent;

  // cdb0 is checked first so it wins when both ports carry the same tag
  function automatic logic [32:0] cdb_snoop(
    input logic [TAG_W-1:0] tag,
    input logic v0, input logic [TAG_W-1:0] t0, input logic [31:0] d0,
    input logic v1, input logic [TAG_W-1:0] t1, input logic [31:0] d1
  );
    if (v0 && (t0 == tag))      return {1'b1, d0};
    else if (v1 && (t1 == tag)) return {1'b1, d1};
    else                        return {1'b0, 32'd0};
  endfunction

  assign rs_full   = &busy;
  assign ready_vec = busy & ~qj_busy & ~qk_busy;
  assign do_disp   = rdy_in & ~flush_pipline & disp_valid & free_found;

  rs_prio_sel #(.N(RS_SIZE), .IDX_W(IDX_W)) u_issue_sel (
    .req   (ready_vec),
    .found (sel_found),
    .idx   (sel_idx)
  );

  rs_prio_sel #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_sel (
    .req   (~busy),
    .found (free_found),
    .idx   (free_idx)
  );

  always_comb begin
    logic [32:0] snj, snk;
    hit_j = '0;
    hit_k = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      snj = cdb_snoop(qj[i], cdb0_valid, cdb0_tag, cdb0_val, cdb1_valid, cdb1_tag, cdb1_val);
      snk = cdb_snoop(qk[i], cdb0_valid, cdb0_tag, cdb0_val, cdb1_valid, cdb1_tag, cdb1_val);
      hit_j[i]   = busy[i] & qj_busy[i] & snj[32];
      hit_k[i]   = busy[i] & qk_busy[i] & snk[32];
      wake_vj[i] = snj[31:0];
      wake_vk[i] = snk[31:0];
    end
  end

  always_comb begin
    disp_snj = cdb_snoop(disp_qj, cdb0_valid, cdb0_tag, cdb0_val, cdb1_valid, cdb1_tag, cdb1_val);
    disp_snk = cdb_snoop(disp_qk, cdb0_valid, cdb0_tag, cdb0_val, cdb1_valid, cdb1_tag, cdb1_val);
    disp_ent.vj         = (disp_qj_busy && disp_snj[32]) ? disp_snj[31:0] : disp_vj;
    disp_ent.vk         = (disp_qk_busy && disp_snk[32]) ? disp_snk[31:0] : disp_vk;
    disp_ent.imm        = disp_imm;
    disp_ent.shamt      = disp_shamt;
    disp_ent.opcode     = disp_opcode;
    disp_ent.funct3     = disp_funct3;
    disp_ent.funct7     = disp_funct7;
    disp_ent.pc         = disp_pc;
    disp_ent.compressed = disp_compressed;
  end

  // Entry payload and tags: no reset needed, validity lives in busy/pending
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush_pipline) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (hit_j[i]) ent[i].vj <= wake_vj[i];
        if (hit_k[i]) ent[i].vk <= wake_vk[i];
      end
      if (do_disp) begin
        ent[free_idx]    <= disp_ent;
        ent_id[free_idx] <= disp_ins_id;
        qj[free_idx]     <= disp_qj;
        qk[free_idx]     <= disp_qk;
      end
    end
  end

  // Control state and registered issue port
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy              <= '0;
      qj_busy           <= '0;
      qk_busy           <= '0;
      have_ins          <= 1'b0;
      ins_id            <= '0;
      rs1_val           <= '0;
      rs2_val           <= '0;
      imm_val           <= '0;
      shamt_val         <= '0;
      opcode            <= '0;
      funct3            <= '0;
      funct7            <= '0;
      request_PC        <= '0;
      is_compressed_ins <= 1'b0;
    end else if (!rdy_in) begin
      have_ins <= 1'b0;
    end else if (flush_pipline) begin
      busy     <= '0;
      have_ins <= 1'b0;
    end else begin
      qj_busy  <= qj_busy & ~hit_j;
      qk_busy  <= qk_busy & ~hit_k;
      have_ins <= sel_found;
      if (sel_found) begin
        busy[sel_idx]     <= 1'b0;
        ins_id            <= ent_id[sel_idx];
        rs1_val           <= ent[sel_idx].vj;
        rs2_val           <= ent[sel_idx].vk;
        imm_val           <= ent[sel_idx].imm;
        shamt_val         <= ent[sel_idx].shamt;
        opcode            <= ent[sel_idx].opcode;
        funct3            <= ent[sel_idx].funct3;
        funct7            <= ent[sel_idx].funct7;
        request_PC        <= ent[sel_idx].pc;
        is_compressed_ins <= ent[sel_idx].compressed;
      end
      if (do_disp) begin
        busy[free_idx]    <= 1'b1;
        qj_busy[free_idx] <= disp_qj_busy & ~disp_snj[32];
        qk_busy[free_idx] <= disp_qk_busy & ~disp_snk[32];
      end
    end
  end

endmodule
